// File: rtl/segmentdisplay_multi_pkg.sv
// Shared constants for the multi-digit 7-segment driver: segment lookup table,
// blank pattern and blink phase encoding.
package segmentdisplay_multi_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    PHASE_HIDDEN  = 1'b0,
    PHASE_VISIBLE = 1'b1
  } blink_phase_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/segmentdisplay_multi_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg7
  import segmentdisplay_multi_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(hex);
  end

endmodule

// File: rtl/segmentdisplay_multi.sv
// Multi-digit 7-segment driver: parallel direct-drive outputs plus a scanned bus,
// with leading-zero blanking, per-digit blink and decimal points.
module segmentdisplay_multi
  import segmentdisplay_multi_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_an,
  input  logic                    latch,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lz_en,
  output logic [7*NUM_DIGITS-1:0] display_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [6:0]              scan_seg,
  output logic                    scan_dp,
  output logic [NUM_DIGITS-1:0]   scan_sel
);

  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    lz_q;

  logic [BW-1:0]           blink_cnt;
  blink_phase_e            blink_phase;
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           scan_idx;

  logic [7*NUM_DIGITS-1:0] seg_raw;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic [NUM_DIGITS-1:0]   dp_next;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   blink_off;
  logic                    all_zero;
  logic [6:0]              sel_seg;
  logic                    sel_dp;
  logic [NUM_DIGITS-1:0]   sel_next;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_to_seg7 u_dec (
      .hex (value_q[4*g +: 4]),
      .seg (seg_raw[7*g +: 7])
    );
  end

  // Walk from the most significant digit down; a digit is blanked while every
  // digit at or above it is zero. Digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
      all_zero      = all_zero & (value_q[4*(k-1) +: 4] == 4'h0);
      lz_blank[k-1] = lz_q & all_zero & (k > 1);
    end
  end

  always_comb begin
    seg_next  = '1;
    dp_next   = '1;
    blink_off = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      blink_off[k]      = blink_q[k] & (blink_phase == PHASE_HIDDEN);
      seg_next[7*k +: 7] = (blink_off[k] | lz_blank[k]) ? SEG_BLANK : seg_raw[7*k +: 7];
      dp_next[k]        = ~(dp_q[k] & ~blink_off[k]);
    end
  end

  // Scan bus samples the already-registered direct outputs, so it trails them by one edge.
  always_comb begin
    sel_seg  = SEG_BLANK;
    sel_dp   = 1'b1;
    sel_next = ~(NUM_DIGITS'(1) << scan_idx);
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (scan_idx == IW'(k)) begin
        sel_seg = display_out[7*k +: 7];
        sel_dp  = dp_out[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_an) begin
      value_q     <= '0;
      dp_q        <= '0;
      blink_q     <= '0;
      lz_q        <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= PHASE_VISIBLE;
      scan_cnt    <= '0;
      scan_idx    <= '0;
      display_out <= '1;
      dp_out      <= '1;
      scan_seg    <= '1;
      scan_dp     <= 1'b1;
      scan_sel    <= ~NUM_DIGITS'(1);
    end else begin
      if (latch) begin
        value_q <= value_in;
        dp_q    <= dp_in;
        blink_q <= blink_in;
        lz_q    <= lz_en;
      end

      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= (blink_phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      display_out <= seg_next;
      dp_out      <= dp_next;
      scan_seg    <= sel_seg;
      scan_dp     <= sel_dp;
      scan_sel    <= sel_next;
    end
  end

endmodule

// File: tb/tb_segmentdisplay_multi.sv
// Directed self-checking bench for segmentdisplay_multi (4 digits, fast blink/scan dividers).
module tb_segmentdisplay_multi;

  logic        clk = 1'b0;
  logic        rst_an;
  logic        latch;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  blink_in;
  logic        lz_en;
  logic [27:0] display_out;
  logic [3:0]  dp_out;
  logic [6:0]  scan_seg;
  logic        scan_dp;
  logic [3:0]  scan_sel;

  int n_checks = 0;
  int n_fail   = 0;

  segmentdisplay_multi #(
    .NUM_DIGITS (4),
    .BLINK_DIV  (8),
    .SCAN_DIV   (4)
  ) dut (
    .clk         (clk),
    .rst_an      (rst_an),
    .latch       (latch),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .blink_in    (blink_in),
    .lz_en       (lz_en),
    .display_out (display_out),
    .dp_out      (dp_out),
    .scan_seg    (scan_seg),
    .scan_dp     (scan_dp),
    .scan_sel    (scan_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [27:0] exp_disp;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Blink phase after post-release edge j (BLINK_DIV = 8, starts visible)
  function automatic logic phase_after(input int j);
    return ((j / 8) % 2) == 0;
  endfunction

  // Expected direct outputs after post-release edge m for the blink/scan run
  function automatic logic [27:0] exp_disp_at(input int m);
    if (m == 0) return '1;
    if (m == 1) return {4{7'h40}};
    return {7'h79, 7'h24, 7'h08, phase_after(m - 1) ? 7'h12 : 7'h7F};
  endfunction

  function automatic logic [3:0] exp_dp_at(input int m);
    if (m <= 1) return 4'hF;
    return {3'b111, phase_after(m - 1) ? 1'b0 : 1'b1};
  endfunction

  task automatic do_latch(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                          input logic lz);
    @(negedge clk);
    value_in = v; dp_in = d; blink_in = b; lz_en = lz; latch = 1'b1;
    @(negedge clk);
    latch = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [27:0] tmp;
    logic [3:0]  sel;
    int          idx;

    vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
    vecs[1] = '{16'h0030, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'hF};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF};
    vecs[4] = '{16'h0100, 4'b1010, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b0101};
    vecs[5] = '{16'h0100, 4'b1000, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b0111};
    vecs[6] = '{16'h3456, 4'b0000, 1'b0, {7'h30, 7'h19, 7'h12, 7'h02}, 4'hF};
    vecs[7] = '{16'h789A, 4'b0001, 1'b0, {7'h78, 7'h00, 7'h18, 7'h08}, 4'b1110};
    vecs[8] = '{16'hBCDE, 4'b0000, 1'b0, {7'h03, 7'h46, 7'h21, 7'h06}, 4'hF};
    vecs[9] = '{16'hF000, 4'b0000, 1'b1, {7'h0E, 7'h40, 7'h40, 7'h40}, 4'hF};

    rst_an = 1'b0; latch = 1'b0; value_in = '0; dp_in = '0; blink_in = '0; lz_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset display_out", display_out, 28'hFFFFFFF);
    check("reset dp_out", {24'd0, dp_out}, 28'hF);
    check("reset scan_sel", {24'd0, scan_sel}, 28'hE);
    check("reset scan_seg", {21'd0, scan_seg}, 28'h7F);
    check("reset scan_dp", {27'd0, scan_dp}, 28'h1);
    rst_an = 1'b1;

    // Decode / leading-zero / dp vectors
    for (int unsigned i = 0; i < 10; i++) begin
      do_latch(vecs[i].value, vecs[i].dp, 4'b0000, vecs[i].lz);
      check($sformatf("vec%0d display_out", i), display_out, vecs[i].exp_disp);
      check($sformatf("vec%0d dp_out", i), {24'd0, dp_out}, {24'd0, vecs[i].exp_dp});
    end

    // Back-to-back latches propagate in order
    @(negedge clk);
    value_in = 16'h1111; dp_in = '0; blink_in = '0; lz_en = 1'b0; latch = 1'b1;
    @(negedge clk);
    value_in = 16'h2222;
    @(negedge clk);
    latch = 1'b0;
    check("b2b first", display_out, {4{7'h79}});
    @(negedge clk);
    check("b2b second", display_out, {4{7'h24}});

    // Blink and scan from a known counter origin: reset, then release with a latch
    @(negedge clk);
    rst_an = 1'b0;
    repeat (3) @(negedge clk);
    rst_an = 1'b1; latch = 1'b1;
    value_in = 16'h12A5; dp_in = 4'b0001; blink_in = 4'b0001; lz_en = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      latch = 1'b0;
      check($sformatf("blink display k=%0d", k), display_out, exp_disp_at(k));
      check($sformatf("blink dp k=%0d", k), {24'd0, dp_out}, {24'd0, exp_dp_at(k)});
      idx = ((k - 1) / 4) % 4;
      sel = 4'b0001 << idx;
      check($sformatf("scan_sel k=%0d", k), {24'd0, scan_sel}, {24'd0, ~sel});
      tmp = exp_disp_at(k - 1);
      check($sformatf("scan_seg k=%0d", k), {21'd0, scan_seg}, {21'd0, tmp[idx*7 +: 7]});
      sel = exp_dp_at(k - 1);
      check($sformatf("scan_dp k=%0d", k), {27'd0, scan_dp}, {27'd0, sel[idx]});
    end

    // Reset mid-operation together with a latch: latch ignored, outputs blank
    @(negedge clk);
    rst_an = 1'b0; latch = 1'b1;
    value_in = 16'hFFFF; dp_in = 4'hF; blink_in = 4'h0; lz_en = 1'b1;
    @(negedge clk);
    check("midrst display_out", display_out, 28'hFFFFFFF);
    check("midrst dp_out", {24'd0, dp_out}, 28'hF);
    check("midrst scan_sel", {24'd0, scan_sel}, 28'hE);
    check("midrst scan_seg", {21'd0, scan_seg}, 28'h7F);
    rst_an = 1'b1; latch = 1'b0;
    @(negedge clk);
    check("midrst captured zero", display_out, {4{7'h40}});
    check("midrst captured dp", {24'd0, dp_out}, 28'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
